serial_pattern_generator: RTL and testbench

//  FSM-based serial bit-stream transmitter: accepts a pattern job over a valid/ready

---
 rtl/serial_pattern_generator_if.sv | 29 ++
 rtl/serial_pattern_generator.sv | 134 +++++++++++++
 tb/tb_serial_pattern_generator.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_generator_if.sv
// Job handshake plus serial output bundle for serial_pattern_generator.
interface serial_pattern_generator_if #(
  parameter int MAX_LEN = 8,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic               in_valid;
  logic               in_ready;
  logic [MAX_LEN-1:0] in_pattern;
  logic [LEN_W-1:0]   in_len;
  logic [REP_W-1:0]   in_repeat;
  logic [GAP_W-1:0]   in_gap;
  logic               a;
  logic               a_valid;
  logic               busy;
  logic               done;

  modport master (
    output in_valid, in_pattern, in_len, in_repeat, in_gap,
    input  in_ready, a, a_valid, busy, done
  );

  modport slave (
    input  in_valid, in_pattern, in_len, in_repeat, in_gap,
    output in_ready, a, a_valid, busy, done
  );
endinterface

// File: rtl/serial_pattern_generator.sv
// Serialises a latched pattern MSB-first, with repeats and idle gaps between them.
module serial_pattern_generator #(
  parameter int MAX_LEN = 8,
  parameter int REP_W   = 4,
  parameter int GAP_W   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  serial_pattern_generator_if.slave     bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LMAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] L1   = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t             state, state_n;
  logic [MAX_LEN-1:0] pat, pat_n;
  logic [LEN_W-1:0]   len, len_n, idx, idx_n, len_c;
  logic [REP_W-1:0]   rep, rep_n;
  logic [GAP_W-1:0]   gap, gap_n, gcnt, gcnt_n;
  logic               a_q, av_q, done_q, rdy_q;
  logic               a_n, av_n, done_n, rdy_n;

  // Shift instead of a variable bit-select so the index width need not match.
  function automatic logic bit_at(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] i);
    logic [MAX_LEN-1:0] s;
    s = p >> i;
    return s[0];
  endfunction

  assign len_c = (bus.in_len > LMAX) ? LMAX : bus.in_len;

  always_comb begin
    state_n = state;
    pat_n   = pat;
    len_n   = len;
    idx_n   = idx;
    rep_n   = rep;
    gap_n   = gap;
    gcnt_n  = gcnt;
    a_n     = 1'b0;
    av_n    = 1'b0;
    done_n  = 1'b0;
    rdy_n   = 1'b0;
    case (state)
      IDLE: begin
        rdy_n = 1'b1;
        if (bus.in_valid && rdy_q) begin
          pat_n = bus.in_pattern;
          len_n = len_c;
          rep_n = bus.in_repeat;
          gap_n = bus.in_gap;
          rdy_n = 1'b0;
          if (len_c != '0) begin
            state_n = SEND;
            idx_n   = len_c - L1;
            a_n     = bit_at(bus.in_pattern, len_c - L1);
            av_n    = 1'b1;
          end else begin
            // Empty job: complete at once, ready returns one cycle later.
            done_n = 1'b1;
          end
        end
      end
      SEND: begin
        if (idx != '0) begin
          idx_n = idx - L1;
          a_n   = bit_at(pat, idx - L1);
          av_n  = 1'b1;
        end else if (rep != '0) begin
          rep_n = rep - REP_W'(1);
          if (gap != '0) begin
            state_n = GAP;
            gcnt_n  = gap - GAP_W'(1);
          end else begin
            idx_n = len - L1;
            a_n   = bit_at(pat, len - L1);
            av_n  = 1'b1;
          end
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
          rdy_n   = 1'b1;
        end
      end
      GAP: begin
        if (gcnt != '0) begin
          gcnt_n = gcnt - GAP_W'(1);
        end else begin
          state_n = SEND;
          idx_n   = len - L1;
          a_n     = bit_at(pat, len - L1);
          av_n    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      pat    <= '0;
      len    <= '0;
      idx    <= '0;
      rep    <= '0;
      gap    <= '0;
      gcnt   <= '0;
      a_q    <= 1'b0;
      av_q   <= 1'b0;
      done_q <= 1'b0;
      rdy_q  <= 1'b0;
    end else begin
      state  <= state_n;
      pat    <= pat_n;
      len    <= len_n;
      idx    <= idx_n;
      rep    <= rep_n;
      gap    <= gap_n;
      gcnt   <= gcnt_n;
      a_q    <= a_n;
      av_q   <= av_n;
      done_q <= done_n;
      rdy_q  <= rdy_n;
    end
  end

  assign bus.in_ready = rdy_q;
  assign bus.a        = a_q;
  assign bus.a_valid  = av_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_serial_pattern_generator.sv
// Directed plus random jobs checked against a per-cycle expected stream built from the job fields.
module tb_serial_pattern_generator;
  localparam int MAX_LEN = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  serial_pattern_generator_if #(.MAX_LEN(8), .REP_W(4), .GAP_W(4)) bus ();

  serial_pattern_generator #(.MAX_LEN(8), .REP_W(4), .GAP_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive a job and advance past the edge that accepts it.
  task automatic accept(input logic [7:0] p, input int ln, input int rp, input int gp, input bit keep);
    int n;
    n = 0;
    bus.in_pattern = p;
    bus.in_len     = 4'(ln);
    bus.in_repeat  = 4'(rp);
    bus.in_gap     = 4'(gp);
    bus.in_valid   = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 60) begin
      step();
      n++;
    end
    chk("accept_ready", {31'd0, bus.in_ready}, 32'd1);
    step();
    if (!keep) bus.in_valid = 1'b0;
  endtask

  // Expected line activity after acceptance: repetitions of L bits separated by gaps, then done.
  task automatic check_stream(input string tag, input logic [7:0] p, input int ln, input int rp, input int gp);
    int L;
    bit q_av[$];
    bit q_a[$];
    L = (ln > MAX_LEN) ? MAX_LEN : ln;
    if (L > 0) begin
      for (int r = 0; r <= rp; r++) begin
        for (int i = L - 1; i >= 0; i--) begin
          q_av.push_back(1'b1);
          q_a.push_back(p[i]);
        end
        if (r < rp)
          for (int g = 0; g < gp; g++) begin
            q_av.push_back(1'b0);
            q_a.push_back(1'b0);
          end
      end
    end
    foreach (q_av[k]) begin
      chk({tag, ":a_valid"},  {31'd0, bus.a_valid},  {31'd0, q_av[k]});
      chk({tag, ":a"},        {31'd0, bus.a},        {31'd0, q_a[k]});
      chk({tag, ":busy"},     {31'd0, bus.busy},     32'd1);
      chk({tag, ":done"},     {31'd0, bus.done},     32'd0);
      chk({tag, ":in_ready"}, {31'd0, bus.in_ready}, 32'd0);
      step();
    end
    chk({tag, ":end_done"},     {31'd0, bus.done},     32'd1);
    chk({tag, ":end_a_valid"},  {31'd0, bus.a_valid},  32'd0);
    chk({tag, ":end_a"},        {31'd0, bus.a},        32'd0);
    chk({tag, ":end_busy"},     {31'd0, bus.busy},     32'd0);
    chk({tag, ":end_in_ready"}, {31'd0, bus.in_ready}, (L > 0) ? 32'd1 : 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_pattern = '0;
    bus.in_len     = '0;
    bus.in_repeat  = '0;
    bus.in_gap     = '0;

    // Reset state, then ready on first edge after release
    #2;
    chk("rst:in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("rst:a_valid",  {31'd0, bus.a_valid},  32'd0);
    chk("rst:a",        {31'd0, bus.a},        32'd0);
    chk("rst:busy",     {31'd0, bus.busy},     32'd0);
    chk("rst:done",     {31'd0, bus.done},     32'd0);
    #10 rst = 1'b1;
    chk("rel:in_ready_before_edge", {31'd0, bus.in_ready}, 32'd0);
    step();
    chk("rel:in_ready", {31'd0, bus.in_ready}, 32'd1);

    // 1: four bits back to back
    accept(8'b0000_1011, 4, 0, 0, 1'b0);
    check_stream("t1", 8'b0000_1011, 4, 0, 0);

    // 2: repeat with a two-cycle gap
    accept(8'b0000_0110, 3, 1, 2, 1'b0);
    check_stream("t2", 8'b0000_0110, 3, 1, 2);

    // 3: empty job
    accept(8'hFF, 0, 2, 1, 1'b0);
    check_stream("t3", 8'hFF, 0, 2, 1);
    step();
    chk("t3:done_once", {31'd0, bus.done},     32'd0);
    chk("t3:ready_back", {31'd0, bus.in_ready}, 32'd1);

    // 4: over-length clamps to MAX_LEN
    accept(8'hA5, 12, 0, 0, 1'b0);
    check_stream("t4", 8'hA5, 12, 0, 0);

    // 5: in_valid held through a job with the payload changing underneath
    accept(8'h0D, 4, 1, 1, 1'b1);
    bus.in_pattern = 8'h03;
    bus.in_len     = 4'd2;
    bus.in_repeat  = 4'd0;
    bus.in_gap     = 4'd0;
    check_stream("t5a", 8'h0D, 4, 1, 1);
    step();
    bus.in_valid = 1'b0;
    check_stream("t5b", 8'h03, 2, 0, 0);

    // 6: reset in the middle of the third bit
    accept(8'b1011_0110, 8, 1, 0, 1'b0);
    step();
    step();
    chk("t6:third_bit_valid", {31'd0, bus.a_valid}, 32'd1);
    #3 rst = 1'b0;
    #1;
    chk("t6:a",        {31'd0, bus.a},        32'd0);
    chk("t6:a_valid",  {31'd0, bus.a_valid},  32'd0);
    chk("t6:busy",     {31'd0, bus.busy},     32'd0);
    chk("t6:done",     {31'd0, bus.done},     32'd0);
    chk("t6:in_ready", {31'd0, bus.in_ready}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    step();
    chk("t6:ready_after", {31'd0, bus.in_ready}, 32'd1);
    chk("t6:no_done",     {31'd0, bus.done},     32'd0);
    accept(8'h96, 5, 1, 3, 1'b0);
    check_stream("t6b", 8'h96, 5, 1, 3);

    // Random jobs
    for (int j = 0; j < 40; j++) begin
      logic [7:0] p;
      int ln, rp, gp, idle;
      p    = 8'($urandom);
      ln   = $urandom_range(0, 10);
      rp   = $urandom_range(0, 3);
      gp   = $urandom_range(0, 3);
      idle = $urandom_range(0, 2);
      for (int d = 0; d < idle; d++) step();
      accept(p, ln, rp, gp, 1'b0);
      check_stream("rnd", p, ln, rp, gp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
